// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the core's data-memory req/gnt/r_valid handshake, backed
//   by a word-organised on-chip RAM. A request is granted after GNT_LATENCY
//   wait states. The read or write happens at the grant edge, and a one-cycle
//   r_valid response follows.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit RAM words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0 (word aligned)
//   GNT_LATENCY  cycles req must be held before gnt (0..15)
//
// Ports
//   CLK           clock, rising edge
//   RES           synchronous active-high reset
//   data_req      request, held until gnt
//   data_we       0 = read, 1 = write
//   data_addr     byte address, bits [1:0] ignored
//   data_be       write byte enables
//   data_wdata    write data
//   data_gnt      request accepted this cycle (combinational)
//   data_r_valid  one-cycle response pulse
//   data_rdata    registered read data
//   data_err      out-of-range access, qualified by data_r_valid
//
// Optional feature
//   DMEM_STALL_LFSR_EN: a 16-bit LFSR (seed 16'hACE1) randomly suppresses gnt.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned GNT_LATENCY = 0
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_r_valid,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (GNT_LATENCY == 0) ? 4'd0 : 4'(GNT_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          rvalid_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [31:0]   word_idx;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          stall;

    // Addresses below BASE_ADDR wrap to huge offsets, so they also fall out of range.
    assign offset   = data_addr - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign in_range = (word_idx < 32'(DEPTH_WORDS));
    assign idx      = word_idx[AW-1:0];

`ifdef DMEM_STALL_LFSR_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge CLK) begin
        if (RES) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Grant from IDLE/RESP only at zero latency. Otherwise grant when the
    // WAIT counter has expired.
    always_comb begin
        data_gnt = 1'b0;
        if (!RES && data_req && !stall) begin
            case (state_q)
                IDLE, RESP: data_gnt = (GNT_LATENCY == 0);
                WAIT:       data_gnt = (cnt_q == '0);
                default:    data_gnt = 1'b0;
            endcase
        end
    end

    // RAM is never cleared by reset.
    always_ff @(posedge CLK) begin
        if (data_gnt && data_we && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_be[b]) begin
                    mem_q[idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            if (data_gnt) begin
                state_q  <= RESP;
                rvalid_q <= 1'b1;
                err_q    <= !in_range;
                if (!in_range) begin
                    rdata_q <= '0;
                end else if (!data_we) begin
                    rdata_q <= mem_q[idx];
                end
            end else begin
                case (state_q)
                    IDLE, RESP: begin
                        if (data_req) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (!data_req) begin
                            state_q <= IDLE;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Reset during RESP discards the response, so the pulse is masked in that cycle.
    assign data_r_valid = rvalid_q & ~RES;
    assign data_err     = err_q & ~RES;
    assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        CLK;
    logic        RES;

    logic        req0, we0, gnt0, rv0, err0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;

    logic        req3, we3, gnt3, rv3, err3;
    logic [31:0] addr3, wd3, rd3;
    logic [3:0]  be3;

    int nerr = 0;
    int nchk = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_LATENCY(0)) u0 (
        .CLK(CLK), .RES(RES), .data_req(req0), .data_we(we0), .data_addr(addr0),
        .data_be(be0), .data_wdata(wd0), .data_gnt(gnt0), .data_r_valid(rv0),
        .data_rdata(rd0), .data_err(err0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_LATENCY(3)) u3 (
        .CLK(CLK), .RES(RES), .data_req(req3), .data_we(we3), .data_addr(addr3),
        .data_be(be3), .data_wdata(wd3), .data_gnt(gnt3), .data_r_valid(rv3),
        .data_rdata(rd3), .data_err(err3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Latency-0 access starting post-edge; returns just after the response edge.
    task automatic acc0(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic experr, input logic [31:0] exprd);
        req0 = 1'b1; we0 = we; addr0 = addr; be0 = be; wd0 = wd;
        #1 chk({tag, ".gnt"}, 32'(gnt0), 32'd1);
        @(posedge CLK); #1;
        req0 = 1'b0; we0 = 1'b0;
        chk({tag, ".rv"}, 32'(rv0), 32'd1);
        chk({tag, ".err"}, 32'(err0), 32'(experr));
        if (!we) chk({tag, ".rd"}, rd0, exprd);
    endtask

    // Latency-3 access: gnt must appear exactly in the 4th request cycle.
    task automatic acc3(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exprd);
        req3 = 1'b1; we3 = we; addr3 = addr; wd3 = wd; be3 = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("%s.gnt%0d", tag, c), 32'(gnt3), 32'(c == 3));
            @(posedge CLK);
        end
        #1;
        req3 = 1'b0; we3 = 1'b0;
        chk({tag, ".rv"}, 32'(rv3), 32'd1);
        chk({tag, ".err"}, 32'(err3), 32'd0);
        if (!we) chk({tag, ".rd"}, rd3, exprd);
        @(posedge CLK); #1;
        chk({tag, ".rv_end"}, 32'(rv3), 32'd0);
    endtask

    initial begin
        RES = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; be3 = '0; wd3 = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.rv", 32'(rv0), 32'd0);
        chk("rst.rd", rd0, 32'd0);
        chk("rst.err", 32'(err0), 32'd0);
        chk("rst.rv3", 32'(rv3), 32'd0);
        req0 = 1'b1;
        #1 chk("rst.gnt", 32'(gnt0), 32'd0);
        req0 = 1'b0;
        RES = 1'b0;
        @(posedge CLK); #1;

        // Basic write/read at latency 0
        acc0("wr10", 1'b1, 32'h10, 4'hF, 32'hCAFEBABE, 1'b0, 32'h0);
        acc0("rd10", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hCAFEBABE);

        // Byte enables
        acc0("wr20", 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0);
        acc0("wr20be", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0);
        acc0("rd20", 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h11BB33DD);

        // Range boundary
        acc0("wr0", 1'b1, 32'h0, 4'hF, 32'h5A5A0001, 1'b0, 32'h0);
        acc0("wrFFC", 1'b1, 32'hFFC, 4'hF, 32'h0BADF00D, 1'b0, 32'h0);
        acc0("rdFFC", 1'b0, 32'hFFC, 4'h0, 32'h0, 1'b0, 32'h0BADF00D);
        acc0("rdoor", 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h0);
        acc0("wroor", 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0);
        acc0("rd0", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h5A5A0001);
        acc0("wr4", 1'b1, 32'h4, 4'hF, 32'h44440004, 1'b0, 32'h0);

        // Back-to-back reads with req held
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        #1 chk("b2b.gnt0", 32'(gnt0), 32'd1);
        @(posedge CLK); #1;
        chk("b2b.rv1", 32'(rv0), 32'd1);
        chk("b2b.rd1", rd0, 32'h5A5A0001);
        addr0 = 32'h4;
        #1 chk("b2b.gnt1", 32'(gnt0), 32'd1);
        @(posedge CLK); #1;
        req0 = 1'b0;
        chk("b2b.rv2", 32'(rv0), 32'd1);
        chk("b2b.rd2", rd0, 32'h44440004);
        @(posedge CLK); #1;
        chk("b2b.rv3", 32'(rv0), 32'd0);
        chk("b2b.err3", 32'(err0), 32'd0);
        chk("b2b.hold", rd0, 32'h44440004);

        // Reset in the response cycle of a granted read
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        #1 chk("rstr.gnt", 32'(gnt0), 32'd1);
        @(posedge CLK); #1;
        req0 = 1'b0;
        RES = 1'b1;
        #1 chk("rstr.rv_mask", 32'(rv0), 32'd0);
        chk("rstr.err_mask", 32'(err0), 32'd0);
        @(posedge CLK); #1;
        RES = 1'b0;
        chk("rstr.rv", 32'(rv0), 32'd0);
        chk("rstr.rd", rd0, 32'd0);
        chk("rstr.err", 32'(err0), 32'd0);
        acc0("rstr.after", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hCAFEBABE);
        @(posedge CLK); #1;

        // Latency 3
        acc3("l3wr", 1'b1, 32'h8, 32'h12345678, 32'h0);
        acc3("l3rd", 1'b0, 32'h8, 32'h0, 32'h12345678);

        // Abandoned request: no gnt, no response, back to IDLE
        req3 = 1'b1; we3 = 1'b0; addr3 = 32'h8;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("abort.gnt%0d", c), 32'(gnt3), 32'd0);
            @(posedge CLK);
        end
        #1 req3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("abort.idle_gnt%0d", c), 32'(gnt3), 32'd0);
            chk($sformatf("abort.idle_rv%0d", c), 32'(rv3), 32'd0);
            @(posedge CLK);
        end
        #1;
        acc3("l3again", 1'b0, 32'h8, 32'h0, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
